riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
Load/store unit between the single-cycle RISC-V core's execute stage and data memory, replacing the core's direct combinational dmem access. It accepts one load or store per instruction and checks alignment and funct3 legality. It drives a ready/ack memory interface with variable latency, then returns sign/zero-extended load data. It stalls the core until the access completes, so data memory can be multi-cycle or external.

Parameters:
ADDR_WIDTH, 32, byte-address width on both core and memory sides.
TIMEOUT, 16, max cycles in REQ without mem_ack before a bus error (>=2).

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
core_valid  in  1  core presents a load/store this cycle.
core_we  in  1  1 = store, 0 = load.
core_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
core_addr  in  ADDR_WIDTH  byte address (rs1 + imm).
core_wdata  in  32  store data (rs2).
core_stall  out  1  freeze PC/regfile this cycle.
core_done  out  1  one-cycle pulse: access complete.
core_rdata  out  32  extended load data, valid when core_done.
core_err  out  1  with core_done: misaligned, illegal funct3 or timeout.
mem_req  out  1  memory request, held until mem_ack.
mem_we  out  1  write enable.
mem_addr  out  ADDR_WIDTH  word-aligned address (core_addr with [1:0] = 0).
mem_wdata  out  32  lane-replicated store data.
mem_be  out  4  byte enables.
mem_rdata  in  32  read word, sampled when mem_ack.
mem_ack  in  1  access complete this cycle.

Behaviour:
- Reset (async, reset=0): state IDLE, timeout counter 0. All outputs 0. mem_req drops immediately even mid-access; the pending access is abandoned.
- States: IDLE, REQ, DONE.
- IDLE: if core_valid, latch we/funct3/addr/wdata and check legality.
  - Load funct3 is legal in {000,001,010,100,101}; store funct3 is legal in {000,001,010}.
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - Illegal or misaligned: next state DONE with err=1, no mem_req ever.
  - Legal: next state REQ, counter cleared.
- REQ: mem_req=1. mem_we/mem_addr/mem_wdata/mem_be are stable, driven from the latched request.
  - mem_ack=1: capture load data, next state DONE, err=0.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ack: next state DONE with err=1, mem_req drops.
- DONE: one cycle only. core_done=1, core_err per the latched error, then return to IDLE. core_valid is ignored in DONE because it belongs to the completing instruction.
- core_stall is combinational:
  - 1 in IDLE when core_valid=1;
  - 1 in REQ;
  - 0 in DONE;
  - 0 in IDLE when core_valid=0.
- Latency:
  - error path: 1 stall cycle;
  - memory path: 1 + ack wait cycles (2 stall cycles minimum when mem_ack is asserted on the first REQ cycle).
- Store lanes (o = addr[1:0]):
  - SB: mem_wdata = 4 copies of wdata[7:0], mem_be = 0001 << o.
  - SH: mem_wdata = 2 copies of wdata[15:0], mem_be = 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - SW: mem_wdata = wdata, mem_be = 1111.
- Loads: mem_be = 1111, mem_wdata = 0.
  - Byte lane = mem_rdata[8*o+7 : 8*o]; half lane = mem_rdata[16*addr[1]+15 : 16*addr[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- core_rdata is registered on ack and held until the next DONE. It is driven 0 in DONE for stores and for errors.
- mem_ack outside REQ is ignored. mem_rdata is sampled only when mem_ack=1 in REQ.
- Outside REQ, mem_we/mem_addr/mem_wdata/mem_be are 0.

Test Plan:
- LW addr 0x10, mem_ack on first REQ cycle with mem_rdata 0xDEADBEEF -> mem_addr 0x10, mem_be 1111, stall 2 cycles, core_done with core_rdata 0xDEADBEEF, err 0.
- LB addr 0x13, mem_rdata 0x80112233, 3-cycle ack delay -> core_rdata 0xFFFFFF80, stall 4 cycles; same with LBU -> 0x00000080; LHU addr 0x12 -> 0x00008011.
- SH addr 0x06, wdata 0x1234ABCD -> mem_addr 0x04, mem_we 1, mem_be 1100, mem_wdata 0xABCDABCD; SB addr 0x01, wdata 0x55 -> mem_be 0010, mem_wdata 0x55555555.
- LW addr 0x0A, then store with funct3 011 -> each: no mem_req, one stall cycle, core_done+core_err=1, core_rdata 0.
- Load with mem_ack never asserted (TIMEOUT=16) -> mem_req high exactly 16 cycles then low, core_done+core_err next cycle, state back to IDLE.
- reset driven 0 asynchronously mid-REQ -> mem_req, core_stall, core_done fall without a clock edge. After release, a new LW completes normally.

Source files
------------

// File: rtl/riscv_lsu_if.sv
// Memory-side bus of the RISC-V load/store unit.
// The LSU drives the request; memory returns ack and read data.
interface riscv_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_be;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: legality check, variable-latency memory
// handshake with timeout, store lane steering and load extension.
module riscv_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_valid,
  input  logic                  core_we,
  input  logic [2:0]            core_funct3,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [31:0]           core_wdata,
  output logic                  core_stall,
  output logic                  core_done,
  output logic [31:0]           core_rdata,
  output logic                  core_err,
  riscv_lsu_if.master           mem
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic        f3_ok;
  logic        align_ok;
  logic        in_req;
  logic [31:0] sh_rd;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  logic [31:0] st_wd;
  logic [3:0]  st_be;

  always_comb begin
    f3_ok = core_we
      ? (core_funct3 inside {3'b000, 3'b001, 3'b010})
      : (core_funct3 inside {3'b000, 3'b001, 3'b010,
                             3'b100, 3'b101});
    unique case (core_funct3[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~core_addr[0];
      2'b10:   align_ok = core_addr[1:0] == 2'b00;
      default: align_ok = 1'b0;
    endcase
  end

  // Lane selection uses the latched address, not the live core bus.
  always_comb begin
    sh_rd = mem.mem_rdata >> {addr_q[1:0], 3'b000};
    ld_b  = sh_rd[7:0];
    ld_h  = addr_q[1] ? mem.mem_rdata[31:16]
                      : mem.mem_rdata[15:0];
    unique case (f3_q)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_data = {24'h0, ld_b};
      3'b101:  ld_data = {16'h0, ld_h};
      default: ld_data = mem.mem_rdata;
    endcase
  end

  always_comb begin
    st_wd = wdata_q;
    st_be = 4'b1111;
    unique case (1'b1)
      (f3_q[1:0] == 2'b00): begin
        st_wd = {4{wdata_q[7:0]}};
        st_be = 4'b0001 << addr_q[1:0];
      end
      (f3_q[1:0] == 2'b01): begin
        st_wd = {2{wdata_q[15:0]}};
        st_be = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wd = wdata_q;
        st_be = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (core_valid) begin
          we_d    = core_we;
          f3_d    = core_funct3;
          addr_d  = core_addr;
          wdata_d = core_wdata;
          if (f3_ok && align_ok) begin
            state_d = REQ;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          state_d = DONE;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : ld_data;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign in_req        = state_q == REQ;
  assign mem.mem_req   = in_req;
  assign mem.mem_we    = in_req & we_q;
  assign mem.mem_addr  = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00}
                                : '0;
  assign mem.mem_wdata = (in_req && we_q) ? st_wd : 32'h0;
  assign mem.mem_be    = in_req ? (we_q ? st_be : 4'b1111) : 4'b0;

  // Reset gating keeps stall low while reset is held.
  assign core_stall = reset &
    (((state_q == IDLE) & core_valid) | in_req);
  assign core_done  = state_q == DONE;
  assign core_err   = (state_q == DONE) & err_q;
  assign core_rdata = rdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: vector table plus
// reset, timeout and stray-ack sequences.
module tb_riscv_lsu;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          lat;
    int          ereq;
    int          estall;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_valid = 1'b0;
  logic        core_we = 1'b0;
  logic [2:0]  core_funct3 = '0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_stall;
  logic        core_done;
  logic [31:0] core_rdata;
  logic        core_err;

  int errors = 0;
  int checks = 0;

  riscv_lsu_if #(.ADDR_WIDTH(32)) mif ();

  riscv_lsu #(
    .ADDR_WIDTH(32),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_valid(core_valid),
    .core_we(core_we),
    .core_funct3(core_funct3),
    .core_addr(core_addr),
    .core_wdata(core_wdata),
    .core_stall(core_stall),
    .core_done(core_done),
    .core_rdata(core_rdata),
    .core_err(core_err),
    .mem(mif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic we, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic [31:0] rd, input int lat,
    input int ereq, input int estall,
    input logic [31:0] eaddr, input logic [3:0] ebe,
    input logic [31:0] ewd, input logic [31:0] erd,
    input logic eerr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rd = rd; v.lat = lat; v.ereq = ereq; v.estall = estall;
    v.eaddr = eaddr; v.ebe = ebe; v.ewd = ewd; v.erd = erd;
    v.eerr = eerr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int          stalls;
    int          reqs;
    bit          done;
    logic [31:0] a_addr;
    logic [31:0] a_wd;
    logic [3:0]  a_be;
    logic        a_we;
    logic [31:0] a_rd;
    logic        a_err;
    stalls = 0; reqs = 0; done = 0;
    a_addr = '0; a_wd = '0; a_be = '0; a_we = 1'b0;
    a_rd = '0; a_err = 1'b0;
    @(negedge clk);
    core_valid  = 1'b1;
    core_we     = v.we;
    core_funct3 = v.f3;
    core_addr   = v.addr;
    core_wdata  = v.wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      mif.mem_ack = 1'b0;
      #1;
      if (core_done) begin
        done  = 1;
        a_rd  = core_rdata;
        a_err = core_err;
        chk({nm, "_done_stall"}, 32'(core_stall), 32'd0);
      end else begin
        if (core_stall) stalls++;
        if (mif.mem_req) begin
          reqs++;
          if (reqs == 1) begin
            a_addr = mif.mem_addr;
            a_wd   = mif.mem_wdata;
            a_be   = mif.mem_be;
            a_we   = mif.mem_we;
          end
          mif.mem_rdata = v.rd;
          mif.mem_ack   = (reqs == v.lat);
        end
        @(negedge clk);
      end
    end
    core_valid = 1'b0;
    mif.mem_ack = 1'b0;
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_stalls"}, stalls, v.estall);
    chk({nm, "_reqs"}, reqs, v.ereq);
    if (v.ereq > 0) begin
      chk({nm, "_addr"}, a_addr, v.eaddr);
      chk({nm, "_be"}, 32'(a_be), 32'(v.ebe));
      chk({nm, "_wdata"}, a_wd, v.ewd);
      chk({nm, "_we"}, 32'(a_we), 32'(v.we));
    end
    chk({nm, "_rdata"}, a_rd, v.erd);
    chk({nm, "_err"}, 32'(a_err), 32'(v.eerr));
    @(negedge clk);
    #1;
    chk({nm, "_hold"}, core_rdata, v.erd);
    chk({nm, "_idle_be"}, 32'(mif.mem_be), 32'd0);
  endtask

  vec_t tv[13];

  initial begin
    tv[0]  = mk(0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 1, 1, 2,
                32'h10, 4'hF, 0, 32'hDEADBEEF, 0);
    tv[1]  = mk(0, 3'b000, 32'h13, 0, 32'h80112233, 3, 3, 4,
                32'h10, 4'hF, 0, 32'hFFFFFF80, 0);
    tv[2]  = mk(0, 3'b100, 32'h13, 0, 32'h80112233, 3, 3, 4,
                32'h10, 4'hF, 0, 32'h00000080, 0);
    tv[3]  = mk(0, 3'b101, 32'h12, 0, 32'h80112233, 3, 3, 4,
                32'h10, 4'hF, 0, 32'h00008011, 0);
    tv[4]  = mk(0, 3'b001, 32'h12, 0, 32'h80112233, 1, 1, 2,
                32'h10, 4'hF, 0, 32'hFFFF8011, 0);
    tv[5]  = mk(1, 3'b001, 32'h06, 32'h1234ABCD, 0, 1, 1, 2,
                32'h04, 4'hC, 32'hABCDABCD, 0, 0);
    tv[6]  = mk(0, 3'b010, 32'h0A, 0, 0, 1, 0, 1,
                0, 0, 0, 0, 1);
    tv[7]  = mk(1, 3'b000, 32'h01, 32'h55, 0, 2, 2, 3,
                32'h00, 4'h2, 32'h55555555, 0, 0);
    tv[8]  = mk(1, 3'b010, 32'h08, 32'hCAFEF00D, 0, 1, 1, 2,
                32'h08, 4'hF, 32'hCAFEF00D, 0, 0);
    tv[9]  = mk(1, 3'b011, 32'h00, 32'h1, 0, 1, 0, 1,
                0, 0, 0, 0, 1);
    tv[10] = mk(0, 3'b000, 32'h21, 0, 32'h00007F00, 1, 1, 2,
                32'h20, 4'hF, 0, 32'h0000007F, 0);
    tv[11] = mk(0, 3'b101, 32'h13, 0, 0, 1, 0, 1,
                0, 0, 0, 0, 1);
    tv[12] = mk(0, 3'b010, 32'h20, 0, 32'h12345678, 0, 16, 17,
                32'h20, 4'hF, 0, 0, 1);

    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;

    core_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_req", 32'(mif.mem_req), 32'd0);
    chk("rst_done", 32'(core_done), 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    @(negedge clk);
    core_valid = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 13; i++)
      run_vec(tv[i], $sformatf("v%0d", i));

    @(negedge clk);
    mif.mem_ack = 1'b1;
    mif.mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    #1;
    chk("stray_ack_done", 32'(core_done), 32'd0);
    chk("stray_ack_req", 32'(mif.mem_req), 32'd0);
    mif.mem_ack = 1'b0;

    @(negedge clk);
    core_valid  = 1'b1;
    core_we     = 1'b0;
    core_funct3 = 3'b010;
    core_addr   = 32'h30;
    @(negedge clk);
    #1;
    chk("mid_req_up", 32'(mif.mem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mif.mem_req), 32'd0);
    chk("mid_rst_stall", 32'(core_stall), 32'd0);
    chk("mid_rst_done", 32'(core_done), 32'd0);
    chk("mid_rst_be", 32'(mif.mem_be), 32'd0);
    @(negedge clk);
    core_valid = 1'b0;
    reset = 1'b1;

    run_vec(tv[0], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
